decode_writeback: RTL

Y86-64 register-file block on the opposite side of the execute stage. It decodes `icode`/`rA`/`rB` into source and destination register IDs and drives `valA`/`valB` into execute. On the clock edge it commits execute's `valE` and memory's `valM` back into fifteen 64-bit program registers. It also holds the sticky processor status (AOK/HLT/INS) that freezes architectural writes.

---
 rtl/decode_writeback_if.sv | 35 +++
 rtl/decode_writeback.sv | 139 +++++++++++++
 2 files changed

// File: rtl/decode_writeback_if.sv
// decode_writeback_if
//   Bundles the decode/writeback bus between the pipeline and the register
//   file block. The master side (execute/memory stages) drives the
//   instruction fields and write-back data. The slave side (the register
//   file) returns operands, decoded IDs and processor status.
//   Ports:
//     wb_en, icode, ifun, rA, rB, cond, valE, valM : master -> slave
//     valA, valB, srcA, srcB, dstE, dstM, stat      : slave -> master
interface decode_writeback_if;
    logic        wb_en;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cond;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [1:0]  stat;

    modport master (
        output wb_en, icode, ifun, rA, rB, cond, valE, valM,
        input  valA, valB, srcA, srcB, dstE, dstM, stat
    );

    modport slave (
        input  wb_en, icode, ifun, rA, rB, cond, valE, valM,
        output valA, valB, srcA, srcB, dstE, dstM, stat
    );
endinterface

// File: rtl/decode_writeback.sv
// decode_writeback
//   Y86-64 decode and write-back register file. It decodes icode/rA/rB into
//   source and destination register IDs and reads the two operands
//   combinationally. It commits valE/valM on the rising clock edge through
//   two write ports, and it holds the sticky AOK/HLT/INS status. A status
//   other than AOK freezes all architectural writes.
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : decode_writeback_if.slave (see interface header)
//   Parameters:
//     STACK_INIT : reset value of %rsp (register 4)
//   Build option:
//     REGFILE_BYPASS_EN : when defined, valA/valB forward same-cycle
//                         write data (dstM has priority over dstE)
module decode_writeback #(
    parameter logic [63:0] STACK_INIT = 64'h200
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_writeback_if.slave   bus
);
    typedef enum logic [1:0] {
        AOK = 2'b00,
        HLT = 2'b01,
        INS = 2'b10
    } stat_e;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [63:0] regs [15];
    stat_e       stat_q;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic        commit;
    logic        unused_ifun;

    // ifun only selects the ALU/branch function upstream; cond carries its effect.
    assign unused_ifun = ^bus.ifun;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            4'h2: begin
                src_a = bus.rA;
                dst_e = bus.cond ? bus.rB : RNONE;   // cmov: write only when taken
            end
            4'h3: dst_e = bus.rB;
            4'h4: begin
                src_a = bus.rA;
                src_b = bus.rB;
            end
            4'h5: begin
                src_b = bus.rB;
                dst_m = bus.rA;
            end
            4'h6: begin
                src_a = bus.rA;
                src_b = bus.rB;
                dst_e = bus.rB;
            end
            4'h8: begin
                src_b = RSP;
                dst_e = RSP;
            end
            4'h9: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
            end
            4'hA: begin
                src_a = bus.rA;
                src_b = RSP;
                dst_e = RSP;
            end
            4'hB: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
                dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    // Halt/invalid instructions decode to no destinations. Gating on them
    // here as well keeps their own writes suppressed if the decode changes.
    assign commit = bus.wb_en && (stat_q == AOK) &&
                    (bus.icode != 4'h0) && (bus.icode <= 4'hB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= (i == 4) ? STACK_INIT : 64'h0;
            stat_q <= AOK;
        end else if (bus.wb_en && stat_q == AOK) begin
            if (bus.icode == 4'h0)
                stat_q <= HLT;
            else if (bus.icode > 4'hB)
                stat_q <= INS;
            if (commit) begin
                // popq %rsp collides both ports on R4; the memory value wins.
                for (int i = 0; i < 15; i++) begin
                    if (dst_m == 4'(i))
                        regs[i] <= bus.valM;
                    else if (dst_e == 4'(i))
                        regs[i] <= bus.valE;
                end
            end
        end
    end

    always_comb begin
        bus.valA = 64'h0;
        bus.valB = 64'h0;
        for (int i = 0; i < 15; i++) begin
            if (src_a == 4'(i)) bus.valA = regs[i];
            if (src_b == 4'(i)) bus.valB = regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        // Later assignments win, so the dstM match overrides the dstE match.
        if (commit) begin
            if (src_a != RNONE && src_a == dst_e) bus.valA = bus.valE;
            if (src_b != RNONE && src_b == dst_e) bus.valB = bus.valE;
            if (src_a != RNONE && src_a == dst_m) bus.valA = bus.valM;
            if (src_b != RNONE && src_b == dst_m) bus.valB = bus.valM;
        end
`endif
    end

    assign bus.srcA = src_a;
    assign bus.srcB = src_b;
    assign bus.dstE = dst_e;
    assign bus.dstM = dst_m;
    assign bus.stat = stat_q;
endmodule
